hex_display_master: RTL and testbench

- Avalon-MM initiator that drives a 4-digit seven-segment output PIO responder.
- Takes a 16-bit binary value plus a per-digit blank mask and encodes it into four active-low segment bytes.
- Writes the resulting 32-bit word to the PIO data register, then optionally reads it back to verify, retrying on mismatch.
- Sits between user logic (counters, measurement blocks) and the HEX PIO slave on the same clock domain.

---
 rtl/hex_display_master_if.sv | 21 ++
 rtl/hex_display_master.sv | 172 +++++++++++++++++
 tb/tb_hex_display_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_master_if.sv
// Avalon-MM bus bundle between the hex display initiator and the HEX PIO responder.
interface hex_display_master_if #(
  parameter int ADDR_W = 2
) ();
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/hex_display_master.sv
// Encodes a 16-bit value into four active-low seven-segment bytes and writes
// the word to the HEX PIO data register, optionally reading it back to verify.
//
// Request handshake: a request is accepted on a rising clk edge where
// value_valid and value_ready are both high; value and blank_mask are sampled
// on that edge. value_ready is high only in IDLE, so value_valid outside IDLE
// is ignored. done pulses for exactly one cycle when the request completes.
module hex_display_master #(
  parameter int ADDR_W    = 2,
  parameter int PIO_ADDR  = 0,
  parameter int VERIFY    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           value,
  input  logic [3:0]            blank_mask,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic                  done,
  output logic                  error,
  input  logic                  clear_err,
  hex_display_master_if.master  avm,
  output logic [2:0]            dbg_state
);

  // HIT is an idle cycle taken instead of WRITE when the word is already on the
  // display, so a skipped request completes with the same latency as a write-only one.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENC   = 3'd1,
    S_HIT   = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [2:0] LP_MAX_RETRY = 3'(MAX_RETRY);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_value;
  logic [3:0]  r_mask;
  logic [31:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_shadow;
  logic        r_shadow_valid;
  logic [31:0] r_rdata;
  logic [2:0]  r_retry_cnt;
  logic        r_error;
  logic [31:0] w_enc;
  logic        w_hit;
  logic        w_match;
  logic        w_set_err;

  // Active-low a..g pattern for one hex nibble, bit0 = segment a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Byte i carries digit i with the decimal point off; blanked digits are all-off.
  always_comb begin
    w_enc = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      w_enc[8*i +: 8] = r_mask[i] ? 8'hFF : {1'b1, seg7(r_value[4*i +: 4])};
    end
  end

  assign w_hit     = r_shadow_valid && (w_enc == r_shadow);
  assign w_match   = (r_rdata == r_word);
  assign w_set_err = (r_state == S_CHECK) && !w_match && (r_retry_cnt >= LP_MAX_RETRY);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (value_valid) w_next = S_ENC;
      S_ENC:   w_next = w_hit ? S_HIT : S_WRITE;
      S_HIT:   w_next = S_DONE;
      S_WRITE: if (!avm.avm_waitrequest) w_next = (VERIFY != 0) ? S_READ : S_DONE;
      S_READ:  if (!avm.avm_waitrequest) w_next = S_CHECK;
      S_CHECK: begin
        if (w_match)                         w_next = S_DONE;
        else if (r_retry_cnt < LP_MAX_RETRY) w_next = S_WRITE;
        else                                 w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: bus strobes are live only in WRITE and READ.
  always_comb begin
    value_ready        = (r_state == S_IDLE);
    done               = (r_state == S_DONE);
    avm.avm_chipselect = (r_state == S_WRITE) || (r_state == S_READ);
    avm.avm_write_n    = (r_state != S_WRITE);
    avm.avm_address    = avm.avm_chipselect ? ADDR_W'(PIO_ADDR) : '0;
  end

  assign avm.avm_writedata = r_wdata;
  assign error             = r_error;
  assign dbg_state         = r_state;

  // Request capture, encoded word, shadow copy of the display and retry bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value        <= '0;
      r_mask         <= '0;
      r_word         <= '0;
      r_wdata        <= 32'hFFFF_FFFF;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_rdata        <= '0;
      r_retry_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (value_valid) begin
          r_value     <= value;
          r_mask      <= blank_mask;
          r_retry_cnt <= '0;
        end
        S_ENC: begin
          r_word <= w_enc;
          if (!w_hit) r_wdata <= w_enc;
        end
        S_WRITE: if (!avm.avm_waitrequest) begin
          r_shadow       <= r_word;
          r_shadow_valid <= 1'b1;
        end
        S_READ: if (!avm.avm_waitrequest) r_rdata <= avm.avm_readdata;
        S_CHECK: if (!w_match && (r_retry_cnt < LP_MAX_RETRY)) begin
          r_retry_cnt    <= r_retry_cnt + 3'd1;
          r_shadow_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sticky error flag; a new failure wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_error <= 1'b0;
    else if (w_set_err) r_error <= 1'b1;
    else if (clear_err) r_error <= 1'b0;
  end

endmodule

// File: tb/tb_hex_display_master.sv
// Directed bench for hex_display_master: a verify-mode instance and a
// write-only instance, each attached to a simple HEX PIO register model.
module tb_hex_display_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic        value_valid = 1'b0;
  logic        value_valid2 = 1'b0;
  logic        clear_err = 1'b0;
  logic        wait_req = 1'b0;
  logic [31:0] stuck_mask = 32'hFFFF_FFFF;
  logic [31:0] pio_reg = '0;
  logic [31:0] pio_reg2 = '0;

  logic        value_ready, done, error;
  logic        value_ready2, done2, error2;
  logic [2:0]  dbg_state, dbg_state2;

  int total = 0;
  int bad = 0;

  hex_display_master_if #(.ADDR_W(2)) avm ();
  hex_display_master_if #(.ADDR_W(2)) avm2 ();

  hex_display_master #(.ADDR_W(2), .PIO_ADDR(0), .VERIFY(1), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .value(value), .blank_mask(blank_mask),
    .value_valid(value_valid), .value_ready(value_ready), .done(done),
    .error(error), .clear_err(clear_err), .avm(avm.master), .dbg_state(dbg_state)
  );

  hex_display_master #(.ADDR_W(2), .PIO_ADDR(0), .VERIFY(0), .MAX_RETRY(2)) dut_wo (
    .clk(clk), .reset(reset), .value(value), .blank_mask(blank_mask),
    .value_valid(value_valid2), .value_ready(value_ready2), .done(done2),
    .error(error2), .clear_err(clear_err), .avm(avm2.master), .dbg_state(dbg_state2)
  );

  // Clock.
  always #5 clk = ~clk;

  // PIO models: zero-latency read, optional stuck-at-0 bits on the read path.
  always @(posedge clk) begin
    if (avm.avm_chipselect && !avm.avm_write_n && !avm.avm_waitrequest)
      pio_reg <= avm.avm_writedata;
    if (avm2.avm_chipselect && !avm2.avm_write_n && !avm2.avm_waitrequest)
      pio_reg2 <= avm2.avm_writedata;
  end
  assign avm.avm_readdata     = pio_reg & stuck_mask;
  assign avm.avm_waitrequest  = wait_req;
  assign avm2.avm_readdata    = pio_reg2;
  assign avm2.avm_waitrequest = 1'b0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE (cycle N) and follow it to completion.
  // Cycle indices are relative to N. Returns with the DUT back in IDLE.
  task automatic run_req(input bit sel, input logic [15:0] v, input logic [3:0] m,
                         output int done_at, output int wr_cnt, output int rd_cnt,
                         output int wr_at, output logic [31:0] wr_data,
                         output logic err_at_done);
    logic cs, wn, wt, d, e;
    logic [31:0] wd;
    value = v;
    blank_mask = m;
    if (sel) value_valid2 = 1'b1;
    else     value_valid  = 1'b1;
    step;
    value_valid = 1'b0;
    value_valid2 = 1'b0;
    done_at = -1; wr_cnt = 0; rd_cnt = 0; wr_at = -1; wr_data = '0; err_at_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      cs = sel ? avm2.avm_chipselect  : avm.avm_chipselect;
      wn = sel ? avm2.avm_write_n     : avm.avm_write_n;
      wt = sel ? avm2.avm_waitrequest : avm.avm_waitrequest;
      wd = sel ? avm2.avm_writedata   : avm.avm_writedata;
      d  = sel ? done2  : done;
      e  = sel ? error2 : error;
      if (cs && !wn && !wt) begin
        wr_cnt++;
        if (wr_at < 0) begin wr_at = c; wr_data = wd; end
      end
      if (cs && wn && !wt) rd_cnt++;
      if (d) begin done_at = c; err_at_done = e; break; end
      step;
    end
    step;
  endtask

  task automatic test_reset;
    total++; if (value_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", value_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
    total++; if (avm.avm_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", avm.avm_chipselect); end
    total++; if (avm.avm_write_n !== 1'b1) begin bad++; $display("FAIL reset_write_n got=%b exp=1", avm.avm_write_n); end
    total++; if (avm.avm_address !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", avm.avm_address); end
    total++; if (avm.avm_writedata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_wdata got=%h exp=ffffffff", avm.avm_writedata); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    total++; if (value_ready2 !== 1'b1 || avm2.avm_chipselect !== 1'b0) begin bad++; $display("FAIL reset_wo got=%b%b exp=10", value_ready2, avm2.avm_chipselect); end
  endtask

  // Digits 4,3,2,1 (right to left) -> 99,B0,A4,F9 with dp off.
  task automatic test_basic_write;
    int da, wc, rc, wa; logic [31:0] wd; logic e;
    run_req(1'b0, 16'h1234, 4'b0000, da, wc, rc, wa, wd, e);
    total++; if (da !== 5) begin bad++; $display("FAIL basic_done_at got=%0d exp=5", da); end
    total++; if (wc !== 1 || wa !== 2) begin bad++; $display("FAIL basic_write got=%0d@%0d exp=1@2", wc, wa); end
    total++; if (wd !== 32'hF9A4B099) begin bad++; $display("FAIL basic_wdata got=%h exp=f9a4b099", wd); end
    total++; if (rc !== 1) begin bad++; $display("FAIL basic_reads got=%0d exp=1", rc); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_error got=%b exp=0", e); end
    total++; if (value_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", value_ready); end
    total++; if (pio_reg !== 32'hF9A4B099) begin bad++; $display("FAIL basic_pio got=%h exp=f9a4b099", pio_reg); end
  endtask

  // Same value again needs no bus traffic; ABCD with digit 3 blanked -> FF,83,C6,A1.
  task automatic test_shadow_skip;
    int da, wc, rc, wa; logic [31:0] wd; logic e;
    run_req(1'b0, 16'h1234, 4'b0000, da, wc, rc, wa, wd, e);
    total++; if (da !== 3) begin bad++; $display("FAIL skip_done_at got=%0d exp=3", da); end
    total++; if (wc !== 0 || rc !== 0) begin bad++; $display("FAIL skip_traffic got=%0d/%0d exp=0/0", wc, rc); end
    run_req(1'b0, 16'hABCD, 4'b1000, da, wc, rc, wa, wd, e);
    total++; if (wd !== 32'hFF83C6A1) begin bad++; $display("FAIL blank_wdata got=%h exp=ff83c6a1", wd); end
    total++; if (da !== 5 || wc !== 1 || rc !== 1) begin bad++; $display("FAIL blank_flow got=%0d/%0d/%0d exp=5/1/1", da, wc, rc); end
  endtask

  // Write stalled in cycles 2..4, read stalled in 6..7: done moves from 5 to 10.
  task automatic test_waitrequest;
    logic [31:0] exp_w;
    exp_w = 32'hC0C08E8E;
    value = 16'h00FF;
    blank_mask = 4'b0000;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      step;
      wait_req = (c == 2 || c == 3 || c == 4 || c == 6 || c == 7);
      if (c <= 5) begin
        total++;
        if (avm.avm_chipselect !== 1'b1 || avm.avm_write_n !== 1'b0 ||
            avm.avm_address !== 2'd0 || avm.avm_writedata !== exp_w) begin
          bad++;
          $display("FAIL stall_write c=%0d got=%b%b %0d %h exp=10 0 %h", c, avm.avm_chipselect,
                   avm.avm_write_n, avm.avm_address, avm.avm_writedata, exp_w);
        end
      end else if (c <= 8) begin
        total++;
        if (avm.avm_chipselect !== 1'b1 || avm.avm_write_n !== 1'b1 || avm.avm_address !== 2'd0) begin
          bad++;
          $display("FAIL stall_read c=%0d got=%b%b %0d exp=11 0", c, avm.avm_chipselect, avm.avm_write_n, avm.avm_address);
        end
      end else if (c == 9) begin
        total++;
        if (avm.avm_chipselect !== 1'b0 || done !== 1'b0) begin
          bad++; $display("FAIL stall_check got=cs%b done%b exp=cs0 done0", avm.avm_chipselect, done);
        end
      end else begin
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL stall_done_at10 got=%b exp=1", done); end
      end
    end
    wait_req = 1'b0;
    step;
    total++; if (pio_reg !== exp_w || error !== 1'b0) begin bad++; $display("FAIL stall_result got=%h err=%b exp=%h err=0", pio_reg, error, exp_w); end
  endtask

  // Read path bit 0 stuck low: three writes, then error with the done pulse.
  task automatic test_retry;
    int da, wc, rc, wa; logic [31:0] wd; logic e;
    stuck_mask = 32'hFFFF_FFFE;
    run_req(1'b0, 16'h1234, 4'b0000, da, wc, rc, wa, wd, e);
    total++; if (wc !== 3 || rc !== 3) begin bad++; $display("FAIL retry_counts got=%0d/%0d exp=3/3", wc, rc); end
    total++; if (da !== 11) begin bad++; $display("FAIL retry_done_at got=%0d exp=11", da); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL retry_error_at_done got=%b exp=1", e); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL retry_error_sticky got=%b exp=1", error); end
    clear_err = 1'b1;
    step;
    clear_err = 1'b0;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL clear_idle got=%b exp=0", error); end
  endtask

  // clear_err in the failing CHECK cycle loses to the set; one cycle later it clears.
  task automatic test_clear_collision;
    value = 16'h0001;
    blank_mask = 4'b0000;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    for (int c = 2; c <= 10; c++) step;
    total++; if (dbg_state !== 3'd5) begin bad++; $display("FAIL collide_in_check got=%0d exp=5", dbg_state); end
    clear_err = 1'b1;
    step;
    total++; if (error !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL collide_set_wins got=err%b done%b exp=err1 done1", error, done); end
    step;
    clear_err = 1'b0;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL collide_clear_next got=%b exp=0", error); end
    stuck_mask = 32'hFFFF_FFFF;
  endtask

  // Reset in WRITE drops the bus at once and forgets the shadow copy.
  task automatic test_reset_mid_write;
    int da, wc, rc, wa; logic [31:0] wd; logic e;
    run_req(1'b0, 16'h5678, 4'b0000, da, wc, rc, wa, wd, e);
    total++; if (wd !== 32'h9282F880 || wc !== 1) begin bad++; $display("FAIL rst_prep got=%h x%0d exp=9282f880 x1", wd, wc); end
    wait_req = 1'b1;
    value = 16'h9ABC;
    value_valid = 1'b1;
    step;
    value_valid = 1'b0;
    step;
    total++; if (avm.avm_chipselect !== 1'b1 || avm.avm_write_n !== 1'b0) begin bad++; $display("FAIL rst_in_write got=%b%b exp=10", avm.avm_chipselect, avm.avm_write_n); end
    #1 reset = 1'b1;
    #1;
    total++; if (avm.avm_chipselect !== 1'b0 || avm.avm_writedata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_async got=cs%b %h exp=cs0 ffffffff", avm.avm_chipselect, avm.avm_writedata); end
    total++; if (value_ready !== 1'b1 || dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%b %0d exp=1 0", value_ready, dbg_state); end
    wait_req = 1'b0;
    step;
    step;
    reset = 1'b0;
    step;
    run_req(1'b0, 16'h5678, 4'b0000, da, wc, rc, wa, wd, e);
    total++; if (wc !== 1 || wd !== 32'h9282F880 || da !== 5) begin bad++; $display("FAIL rst_rewrite got=%0d %h @%0d exp=1 9282f880 @5", wc, wd, da); end
  endtask

  // Write-only instance: 0F00 -> C0,8E,C0,C0, no read, done at 3.
  task automatic test_write_only;
    int da, wc, rc, wa; logic [31:0] wd; logic e;
    run_req(1'b1, 16'h0F00, 4'b0000, da, wc, rc, wa, wd, e);
    total++; if (wd !== 32'hC08EC0C0 || wc !== 1 || wa !== 2) begin bad++; $display("FAIL wo_write got=%h x%0d @%0d exp=c08ec0c0 x1 @2", wd, wc, wa); end
    total++; if (rc !== 0) begin bad++; $display("FAIL wo_reads got=%0d exp=0", rc); end
    total++; if (da !== 3) begin bad++; $display("FAIL wo_done_at got=%0d exp=3", da); end
    total++; if (pio_reg2 !== 32'hC08EC0C0) begin bad++; $display("FAIL wo_pio got=%h exp=c08ec0c0", pio_reg2); end
  endtask

  initial begin
    #1;
    step;
    step;
    test_reset;
    reset = 1'b0;
    step;
    test_basic_write;
    test_shadow_skip;
    test_waitrequest;
    test_retry;
    test_clear_collision;
    test_reset_mid_write;
    test_write_only;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
